prom_arb: RTL
=============

Name: prom_arb

Overview:
- Two-master arbiter that shares the single 1024 x 32 bit boot PROM between the CPU instruction-fetch port (I) and the CPU data port (D).
- Sits between the CPU bus masters and the PROM slave; sequences each PROM read through an issue/wait/response state machine.
- Rejects writes locally, so the PROM never sees one.
- Tolerates the PROM's toggling ack (ack inverts on each strobed read cycle and holds its value while the strobe is low).

Parameters:
- TIMEOUT, 255, WAIT cycles without slave ack before an error response (used only with PROM_ARB_TIMEOUT_EN); range 3..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_stb  in  1  fetch request; held until i_ack
- i_addr  in  10  fetch word address [11:2]
- i_data  out  32  fetch read data, registered
- i_ack  out  1  one-cycle completion pulse
- i_err  out  1  error qualifier, valid with i_ack
- d_stb  in  1  data request; held until d_ack
- d_we  in  1  data write request
- d_addr  in  10  data word address [11:2]
- d_data  out  32  data read data, registered
- d_ack  out  1  one-cycle completion pulse
- d_err  out  1  error qualifier, valid with d_ack
- p_stb  out  1  PROM strobe
- p_we  out  1  PROM write enable; constant 0
- p_addr  out  10  PROM word address
- p_data  in  32  PROM read data
- p_ack  in  1  PROM ack (toggling, may be stale)

Behaviour:
- Reset values:
  - all outputs 0; state IDLE
  - last-grant flag = D, so I wins the first tie
  - timeout counter 0
- Master protocol:
  - master holds stb/addr/we stable until its ack
  - master deasserts stb at the clock edge where it samples ack=1
- States:
  - IDLE -> ISSUE: a read request is pending and is granted.
  - IDLE -> RESP: a granted D request has d_we=1.
  - ISSUE -> WAIT: always, after exactly 1 cycle.
  - WAIT -> RESP: p_ack=1, or (feature on) timeout.
  - RESP -> IDLE: always.
- Arbitration (IDLE only):
  - one requester pending: grant it
  - both pending: grant the one not in the last-grant flag
  - last-grant flag updates on the grant
  - grant and address are latched; they do not change until RESP
- ISSUE:
  - p_stb=1, p_addr = latched address
  - p_ack ignored, because it may be stale from the previous access
- WAIT:
  - p_stb=1
  - on p_ack=1: capture p_data into the granted master's data register, go to RESP
- RESP:
  - p_stb=0
  - granted master's ack=1 for exactly one cycle, with err and data valid
  - data registers hold their value until the next RESP for that master
- Write by D:
  - no PROM access
  - RESP with d_err=1; d_data unchanged
- Latency:
  - read: request in IDLE -> ack 3 cycles later minimum (IDLE, ISSUE, WAIT x>=1, RESP); 4 cycles when p_ack was stale-high
  - write rejection: 1 cycle after IDLE
- Ordering and throughput:
  - p_stb is never asserted in IDLE or RESP
  - at most one outstanding PROM access
  - back-to-back requests by the same master insert the IDLE cycle
- rst in any state:
  - return to IDLE, drop p_stb, no ack emitted
  - aborted request is lost; the master re-requests

Optional Feature:
- PROM_ARB_TIMEOUT_EN defined:
  - 8-bit counter clears on entry to WAIT and increments each WAIT cycle
  - at count == TIMEOUT with no p_ack: go to RESP, ack with err=1, data register loaded with 32'h0
  - p_ack arriving in the same cycle as the timeout wins (normal response)
- Undefined:
  - no counter; WAIT waits indefinitely
  - err only for D writes

Decomposition:
- Package prom_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - grant encoding (GNT_I=0, GNT_D=1)
  - PROM_AW=10, DW=32
  - TIMEOUT_DATA=32'h0
- Sub-module prom_arb_rr: 2-way round-robin picker (req[1:0], last, en -> gnt, last_next). Pure combinational next-state plus a flag flop.

Test Plan:
- Single I read, addr 10'h004, PROM word 32'h12345678, p_ack previously 0 -> i_ack pulses 3 cycles after request with i_data=32'h12345678, i_err=0; p_stb high exactly 2 cycles.
- Second I read right after, p_ack stale at 1 -> ISSUE ignores it; i_ack 4 cycles after request; data from new address.
- i_stb and d_stb rise together, both held -> I served first, D next, then I; no cycle with p_stb high in IDLE/RESP.
- d_stb with d_we=1, addr 10'h3FF -> d_ack and d_err=1 one cycle later; p_stb never asserted; d_data unchanged.
- rst asserted during WAIT -> next cycle p_stb=0, no ack; re-issued request completes normally.
- (PROM_ARB_TIMEOUT_EN, TIMEOUT=5) PROM model never acks -> ack with err=1 and data 32'h0 after 5 WAIT cycles; p_ack on cycle 5 -> normal data, err=0.

Source files
------------

// File: rtl/prom_arb_pkg.sv
// prom_arb_pkg: shared types and widths for the boot PROM arbiter.
package prom_arb_pkg;

  localparam int unsigned PROM_AW = 10;
  localparam int unsigned DW      = 32;
  localparam int unsigned CNT_W   = 8;

  localparam logic [DW-1:0] TIMEOUT_DATA = 32'h0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

endpackage

// File: rtl/prom_arb_rr.sv
// prom_arb_rr: two-way round-robin picker; the last-grant flag favours the
// other requester on a tie and only moves when a grant is actually taken.
module prom_arb_rr
  import prom_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output gnt_e       gnt_c
);

  gnt_e last_q, last_d;

  // req[0] is the fetch port, req[1] the data port
  always_comb begin
    gnt_c  = GNT_I;
    last_d = last_q;
    unique case (req)
      2'b01:   gnt_c = GNT_I;
      2'b10:   gnt_c = GNT_D;
      2'b11:   gnt_c = (last_q == GNT_D) ? GNT_I : GNT_D;
      default: gnt_c = GNT_I;
    endcase
    if (en && (req != 2'b00)) begin
      last_d = gnt_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= GNT_D;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/prom_arb.sv
// prom_arb: shares the boot PROM between the fetch (I) and data (D) ports.
// Define PROM_ARB_TIMEOUT_EN to bound the WAIT state by TIMEOUT cycles.
module prom_arb
  import prom_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_stb,
  input  logic [PROM_AW-1:0] i_addr,
  output logic [DW-1:0]      i_data,
  output logic               i_ack,
  output logic               i_err,
  input  logic               d_stb,
  input  logic               d_we,
  input  logic [PROM_AW-1:0] d_addr,
  output logic [DW-1:0]      d_data,
  output logic               d_ack,
  output logic               d_err,
  output logic               p_stb,
  output logic               p_we,
  output logic [PROM_AW-1:0] p_addr,
  input  logic [DW-1:0]      p_data,
  input  logic               p_ack
);

  if (TIMEOUT < 3 || TIMEOUT > 255) begin : g_timeout_range
    $error("prom_arb: TIMEOUT must be within 3..255");
  end

  state_e             state_q, state_d;
  gnt_e               gnt_q, gnt_d;
  gnt_e               rr_gnt_c;
  logic               rr_en;
  logic [PROM_AW-1:0] p_addr_q, p_addr_d;
  logic [DW-1:0]      i_data_q, i_data_d;
  logic [DW-1:0]      d_data_q, d_data_d;
  logic               i_ack_q, i_ack_d, i_err_q, i_err_d;
  logic               d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic               p_stb_q, p_stb_d;
  logic               done;
  logic               done_err;
  logic [DW-1:0]      done_data;
`ifdef PROM_ARB_TIMEOUT_EN
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

  prom_arb_rr u_rr (
    .clk   (clk),
    .rst   (rst),
    .req   ({d_stb, i_stb}),
    .en    (rr_en),
    .gnt_c (rr_gnt_c)
  );

  // Next state and registered outputs; ack/strobe are decoded from the state
  // being entered so they line up with the state they belong to.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    p_addr_d  = p_addr_q;
    i_data_d  = i_data_q;
    d_data_d  = d_data_q;
    i_ack_d   = 1'b0;
    i_err_d   = 1'b0;
    d_ack_d   = 1'b0;
    d_err_d   = 1'b0;
    p_stb_d   = 1'b0;
    rr_en     = 1'b0;
    done      = 1'b0;
    done_err  = 1'b0;
    done_data = p_data;
`ifdef PROM_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_stb || d_stb) begin
          rr_en = 1'b1;
          gnt_d = rr_gnt_c;
          if ((rr_gnt_c == GNT_D) && d_we) begin
            // writes are refused without touching the PROM
            state_d = RESP;
            d_ack_d = 1'b1;
            d_err_d = 1'b1;
          end else begin
            state_d  = ISSUE;
            p_stb_d  = 1'b1;
            p_addr_d = (rr_gnt_c == GNT_D) ? d_addr : i_addr;
          end
        end
      end
      ISSUE: begin
        // p_ack may still be high from the previous access; not sampled here
        state_d = WAIT;
        p_stb_d = 1'b1;
`ifdef PROM_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        p_stb_d = 1'b1;
`ifdef PROM_ARB_TIMEOUT_EN
        cnt_d   = cnt_q + CNT_W'(1);
`endif
        if (p_ack) begin
          done = 1'b1;
        end
`ifdef PROM_ARB_TIMEOUT_EN
        else if (cnt_d == CNT_W'(TIMEOUT)) begin
          done      = 1'b1;
          done_err  = 1'b1;
          done_data = TIMEOUT_DATA;
        end
`endif
        if (done) begin
          state_d = RESP;
          p_stb_d = 1'b0;
          if (gnt_q == GNT_I) begin
            i_ack_d  = 1'b1;
            i_err_d  = done_err;
            i_data_d = done_data;
          end else begin
            d_ack_d  = 1'b1;
            d_err_d  = done_err;
            d_data_d = done_data;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= GNT_I;
      p_addr_q <= '0;
      i_data_q <= '0;
      d_data_q <= '0;
      i_ack_q  <= 1'b0;
      i_err_q  <= 1'b0;
      d_ack_q  <= 1'b0;
      d_err_q  <= 1'b0;
      p_stb_q  <= 1'b0;
`ifdef PROM_ARB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      p_addr_q <= p_addr_d;
      i_data_q <= i_data_d;
      d_data_q <= d_data_d;
      i_ack_q  <= i_ack_d;
      i_err_q  <= i_err_d;
      d_ack_q  <= d_ack_d;
      d_err_q  <= d_err_d;
      p_stb_q  <= p_stb_d;
`ifdef PROM_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign i_data = i_data_q;
  assign i_ack  = i_ack_q;
  assign i_err  = i_err_q;
  assign d_data = d_data_q;
  assign d_ack  = d_ack_q;
  assign d_err  = d_err_q;
  assign p_stb  = p_stb_q;
  assign p_we   = 1'b0;
  assign p_addr = p_addr_q;

endmodule
